// File: rtl/phase_pkg.sv
// phase_pkg: shared constants and FSM state type for the phase generator.
//   IDX_BITS  : phase bits used as the sine table index
//   LUT_DEPTH : entries in the downstream sine table
//   INDEX_W   : width of the index bus into the table
//   state_e   : IDLE (frozen) / RUN (ticking)
package phase_pkg;

   localparam int IDX_BITS  = 4;
   localparam int LUT_DEPTH = 16;
   localparam int INDEX_W   = 8;

   typedef enum logic {
      IDLE = 1'b0,
      RUN  = 1'b1
   } state_e;

endpackage

// File: rtl/phase_gen_tick_div.sv
// tick_div: sample-rate prescaler.
//   clk        in  : system clock
//   reset      in  : synchronous active-high reset
//   run_i      in  : FSM is in RUN this cycle
//   enable_i   in  : enable request; low ends the run and clears the count
//   clear_i    in  : phase_clear pulse, restarts the period
//   div_act_i  in  : active tick period minus 1
//   tick_o     out : combinational, high in the cycle that closes a period
module tick_div #(
   parameter int DIV_WIDTH = 16
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 run_i,
   input  logic                 enable_i,
   input  logic                 clear_i,
   input  logic [DIV_WIDTH-1:0] div_act_i,
   output logic                 tick_o
);

   logic [DIV_WIDTH-1:0] cnt_q;
   logic [DIV_WIDTH-1:0] cnt_d;

   assign tick_o = run_i && (cnt_q == div_act_i);

   always_comb begin
      cnt_d = cnt_q + 1'b1;
      // Count sits at 0 whenever the generator is not actively running,
      // so a fresh RUN always starts a full period.
      if (clear_i || !run_i || !enable_i || tick_o) begin
         cnt_d = '0;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/phase_gen.sv
// phase_gen: phase-accumulator front end for the 16-entry sine table.
//   clk         in  : system clock, rising edge
//   reset       in  : synchronous active-high reset
//   enable      in  : 1 = RUN, 0 = IDLE (freeze)
//   phase_clear in  : zeroes accumulator, prescaler and index outputs
//   tune_in     in  : phase increment per tick
//   div_in      in  : tick period minus 1, in clocks
//   tune_load   in  : captures tune_in/div_in into the shadow registers
//   tune_busy   out : shadow holds a value not yet applied
//   index       out : {0, acc top 4 bits}, registered
//   index_valid out : one-cycle pulse after each tick
module phase_gen
   import phase_pkg::*;
#(
   parameter int ACC_WIDTH = 16,
   parameter int DIV_WIDTH = 16
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 enable,
   input  logic                 phase_clear,
   input  logic [ACC_WIDTH-1:0] tune_in,
   input  logic [DIV_WIDTH-1:0] div_in,
   input  logic                 tune_load,
   output logic                 tune_busy,
   output logic [INDEX_W-1:0]   index,
   output logic                 index_valid
);

   state_e               state_q;
   logic [ACC_WIDTH-1:0] acc_q;
   logic [ACC_WIDTH-1:0] tune_act_q;
   logic [DIV_WIDTH-1:0] div_act_q;
   logic [ACC_WIDTH-1:0] tune_sh_q;
   logic [DIV_WIDTH-1:0] div_sh_q;
   logic                 pending_q;
   logic [INDEX_W-1:0]   index_q;
   logic                 index_valid_q;

   logic                 tick;
   logic                 apply;
   logic [ACC_WIDTH-1:0] acc_sum;
   logic [INDEX_W-1:0]   index_d;

   tick_div #(
      .DIV_WIDTH (DIV_WIDTH)
   ) u_tick_div (
      .clk       (clk),
      .reset     (reset),
      .run_i     (state_q == RUN),
      .enable_i  (enable),
      .clear_i   (phase_clear),
      .div_act_i (div_act_q),
      .tick_o    (tick)
   );

   assign acc_sum = acc_q + tune_act_q;
   assign index_d = {{(INDEX_W-IDX_BITS){1'b0}}, acc_sum[ACC_WIDTH-1 -: IDX_BITS]};

   // In RUN the shadow is only promoted on a tick boundary so a sample never
   // mixes old and new settings; in IDLE nothing is being produced, so it is
   // promoted straight away. phase_clear suppresses the tick and the apply.
   assign apply = pending_q && !phase_clear && ((state_q == RUN) ? tick : 1'b1);

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q       <= IDLE;
         acc_q         <= '0;
         tune_act_q    <= '0;
         div_act_q     <= '0;
         tune_sh_q     <= '0;
         div_sh_q      <= '0;
         pending_q     <= 1'b0;
         index_q       <= '0;
         index_valid_q <= 1'b0;
      end else begin
         case (state_q)
            IDLE:    if (enable)  state_q <= RUN;
            RUN:     if (!enable) state_q <= IDLE;
            default: state_q <= IDLE;
         endcase

         if (phase_clear) begin
            acc_q         <= '0;
            index_q       <= '0;
            index_valid_q <= 1'b0;
         end else if (tick) begin
            // Sum uses the current tuning word; an apply on this same edge
            // only affects the following tick.
            acc_q         <= acc_sum;
            index_q       <= index_d;
            index_valid_q <= 1'b1;
         end else begin
            index_valid_q <= 1'b0;
         end

         if (apply) begin
            tune_act_q <= tune_sh_q;
            div_act_q  <= div_sh_q;
         end

         // A load coincident with an apply re-arms pending with the new shadow.
         if (tune_load) begin
            tune_sh_q <= tune_in;
            div_sh_q  <= div_in;
            pending_q <= 1'b1;
         end else if (apply) begin
            pending_q <= 1'b0;
         end
      end
   end

   assign tune_busy   = pending_q;
   assign index       = index_q;
   assign index_valid = index_valid_q;

endmodule

// File: doc/phase_gen.md
# phase_gen

Phase-accumulator front end that drives the 16-entry sine `lookuptable`. It divides the system clock down to a programmable sample rate and adds a frequency tuning word to a phase accumulator on every sample tick. It presents the top 4 phase bits as the 8-bit table index, with a one-cycle valid strobe. Tuning updates are double-buffered and take effect only on a tick boundary, so the output waveform never glitches mid-sample.

## Interface

Parameters:
- `ACC_WIDTH`, default 16: phase accumulator width; must be ≥ 4.
- `DIV_WIDTH`, default 16: sample-rate divider width.

Ports:
- `clk` in 1: single system clock; all logic on rising edge.
- `reset` in 1: reset is synchronous and active-high.
- `enable` in 1: 1 = run (state RUN), 0 = freeze (state IDLE).
- `phase_clear` in 1: synchronous pulse; zeroes the accumulator and the prescaler.
- `tune_in` in `ACC_WIDTH`: frequency tuning word (phase increment per tick).
- `div_in` in `DIV_WIDTH`: tick period minus 1, in clocks.
- `tune_load` in 1: single-cycle strobe; captures `tune_in`/`div_in` into the shadow registers.
- `tune_busy` out 1: shadow holds a value not yet applied.
- `index` out 8: `{4'b0, acc[ACC_WIDTH-1 -: 4]}`, registered; feeds `lookuptable.in`.
- `index_valid` out 1: one-cycle pulse, high in the cycle after each tick.

## Operation

- Registers: `acc`, `cnt`, `tune_act`, `div_act`, `tune_sh`, `div_sh`, `pending`, `state`.
- Reset values: all registers and outputs 0; `state` = IDLE.
- **FSM, state IDLE**:
  - `cnt` held at 0; `acc` held.
  - No ticks; `index_valid` = 0.
  - A pending shadow is applied to the active registers on the next edge; `pending` clears.
  - `enable`=1 moves to RUN.
- **FSM, state RUN**:
  - `cnt` increments each clock.
  - When `cnt == div_act`, that cycle is a tick and `cnt` wraps to 0.
  - `enable`=0 moves to IDLE and clears `cnt`.
- **On a tick edge**:
  - `acc <= acc + tune_act`, mod 2^ACC_WIDTH, natural wrap with no saturation.
  - `index <= {4'b0, (acc + tune_act)[ACC_WIDTH-1 -: 4]}`.
  - `index_valid <= 1`.
  - If `pending`: `tune_act <= tune_sh`, `div_act <= div_sh`, `pending <= 0`. The new values govern the next tick, not the current sum.
- **`tune_load`**:
  - Sets `tune_sh`/`div_sh` and `pending` = 1.
  - A second load while pending overwrites the shadow (last wins); `pending` stays 1.
  - A load in the same cycle as an apply: the apply uses the old shadow, the new shadow is captured, and `pending` stays 1.
- **`tune_busy`** = `pending`.
- **`phase_clear`**:
  - `acc`, `cnt`, `index` <= 0; `index_valid` <= 0.
  - Shadow and active registers are untouched.
  - It overrides a coincident tick.
- **Priority**: `reset` > `phase_clear` > tick > hold.
- **`div_act` = 0**: tick every clock in RUN.
- **`tune_act` = 0**: ticks still pulse `index_valid`, and `index` stays constant.

## Timing

- Tick latency: `index`/`index_valid` update on the edge that ends the tick cycle; the outputs are visible the next cycle.
- `index_valid` width: exactly 1 cycle, except back-to-back when `div_act` = 0.
- Tick period: `div_act`+1 clocks in steady RUN. The first tick after entering RUN comes `div_act`+1 clocks after `enable` rises.
- `tune_busy`: rises the cycle after `tune_load`. It falls the cycle after the applying tick in RUN, or the cycle after the load edge + 1 in IDLE.
- `reset` mid-operation: on the next edge everything returns to reset values; the pending load is lost.
- Downstream `lookuptable` is combinational, so the sample is valid in the same cycle as `index_valid`.

## Structure

- Package `phase_pkg`:
  - `IDX_BITS` = 4
  - `LUT_DEPTH` = 16
  - `INDEX_W` = 8
  - FSM state enum {IDLE, RUN}
- Sub-module `tick_div`: prescaler (`cnt`, `div_act` compare, clear) producing the `tick` pulse.
- Accumulator, shadow logic and FSM live in `phase_gen`.

## Test plan

- Reset, load `tune`=0x1000, `div`=0, enable: `index_valid` is high every cycle; `index` runs 1,2,…,15,0,1 (wrap); `tune_busy` is high one cycle.
- `tune`=0x0800, `div`=3: a valid pulse every 4 clocks; `index` runs 0,1,1,2,2,…; verify the first tick comes 4 clocks after `enable`.
- Mid-run load `tune`=0x2000 just after a tick: the next tick still adds the old word, the following tick adds 0x2000; `tune_busy` is high until the apply.
- Two `tune_load` strobes between ticks (0x3000 then 0x4000): only 0x4000 is ever applied.
- `phase_clear` coincident with a tick while `acc`=0x7000: next cycle `index`=0, `index_valid`=0; subsequent ticks restart from 0.
- Drop `enable` for 10 cycles mid-period, then assert `reset` during RUN with a load pending: with `enable` low there are no valid pulses, `acc` holds and the pending load applies in IDLE; `reset` returns all outputs to 0 and `tune_busy` to 0.
